// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_ctrl_pkg;

  localparam int REG_AW_DEF = 5;

  // Controller state, visible on ctrl_state for debug/trace.
  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_LU_STALL = 2'd1,
    S_MEM_WAIT = 2'd2,
    S_REDIRECT = 2'd3
  } ctrl_state_e;

  // Writeback source select used by the core; the load encoding defines ld_E.
  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_LOAD = 2'd1,
    WB_PC4  = 2'd2,
    WB_CSR  = 2'd3
  } wb_sel_e;

  function automatic logic is_load(input logic reg_wr_en, input wb_sel_e wb_sel);
    return reg_wr_en && (wb_sel == WB_LOAD);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Hazard controller bus: core-side hazard inputs and pipeline-register controls.
// Optional perf counter outputs appear when HAZARD_PERF_EN is defined.
interface hazard_ctrl_if
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_AW = 5
);
  logic [REG_AW-1:0] rs1_addr_D;
  logic [REG_AW-1:0] rs2_addr_D;
  logic              rs1_used_D;
  logic              rs2_used_D;
  logic [REG_AW-1:0] rd_addr_E;
  logic              ld_E;
  logic              br_taken_E;
  logic              mem_busy;
  logic              pc_en;
  logic              if_id_en;
  logic              if_id_flush;
  logic              id_ex_en;
  logic              id_ex_flush;
  logic              ex_mem_en;
  logic              mem_wb_en;
  ctrl_state_e       ctrl_state;
  logic              mem_timeout;
`ifdef HAZARD_PERF_EN
  logic [31:0]       perf_stall_cnt;
  logic [31:0]       perf_flush_cnt;
  logic [31:0]       perf_freeze_cnt;
`endif

  modport master (
    output rs1_addr_D, rs2_addr_D, rs1_used_D, rs2_used_D,
           rd_addr_E, ld_E, br_taken_E, mem_busy,
    input  pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
           ex_mem_en, mem_wb_en, ctrl_state, mem_timeout
`ifdef HAZARD_PERF_EN
    , input perf_stall_cnt, perf_flush_cnt, perf_freeze_cnt
`endif
  );

  modport slave (
    input  rs1_addr_D, rs2_addr_D, rs1_used_D, rs2_used_D,
           rd_addr_E, ld_E, br_taken_E, mem_busy,
    output pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
           ex_mem_en, mem_wb_en, ctrl_state, mem_timeout
`ifdef HAZARD_PERF_EN
    , output perf_stall_cnt, perf_flush_cnt, perf_freeze_cnt
`endif
  );

endinterface

// File: rtl/hazard_ctrl_wait_cnt.sv
// hazard_wait_cnt: counts consecutive mem_busy cycles, saturating at
// MEM_TIMEOUT, and raises a sticky timeout flag the cycle it gets there.
module hazard_wait_cnt #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic busy,
  output logic timeout
);
  localparam logic [15:0] LIMIT = 16'(MEM_TIMEOUT);

  logic [15:0] cnt;
  logic [15:0] cnt_nxt;

  // Saturating increment.
  always_comb begin
    cnt_nxt = (cnt >= LIMIT) ? cnt : cnt + 16'd1;
  end

  // Count while busy, clear on release; flag is only cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      timeout <= 1'b0;
    end else if (busy) begin
      cnt <= cnt_nxt;
      if (cnt_nxt == LIMIT) timeout <= 1'b1;
    end else begin
      cnt <= '0;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for the 5-stage core.
// Freeze on mem_busy, squash on taken branch, one-bubble load-use stall.
// Define HAZARD_PERF_EN to add stall/flush/freeze performance counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int          REG_AW      = REG_AW_DEF,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input logic         clk,
  input logic         rst_n,
  hazard_ctrl_if.slave bus
);
  logic [REG_AW-1:0] rd_e;
  logic              lu_hazard;
  logic              redirect;
  logic              stall;
  ctrl_state_e       state;
  ctrl_state_e       state_nxt;

  assign rd_e      = bus.rd_addr_E;
  assign lu_hazard = bus.ld_E && (rd_e != '0) &&
                     ((bus.rs1_used_D && (bus.rs1_addr_D == rd_e)) ||
                      (bus.rs2_used_D && (bus.rs2_addr_D == rd_e)));
  assign redirect  = bus.br_taken_E && !bus.mem_busy;
  assign stall     = lu_hazard && !bus.br_taken_E && !bus.mem_busy;

  // Register-control outputs, zero latency, freeze > redirect > load-use.
  always_comb begin
    bus.pc_en       = 1'b1;
    bus.if_id_en    = 1'b1;
    bus.if_id_flush = 1'b0;
    bus.id_ex_en    = 1'b1;
    bus.id_ex_flush = 1'b0;
    bus.ex_mem_en   = 1'b1;
    bus.mem_wb_en   = 1'b1;
    if (bus.mem_busy) begin
      bus.pc_en     = 1'b0;
      bus.if_id_en  = 1'b0;
      bus.id_ex_en  = 1'b0;
      bus.ex_mem_en = 1'b0;
      bus.mem_wb_en = 1'b0;
    end else if (bus.br_taken_E) begin
      bus.if_id_flush = 1'b1;
      bus.id_ex_flush = 1'b1;
    end else if (lu_hazard) begin
      bus.pc_en       = 1'b0;
      bus.if_id_en    = 1'b0;
      bus.id_ex_flush = 1'b1;
    end
  end

  // Next state from the same priority; a load-use stall always lasts one cycle.
  always_comb begin
    state_nxt = S_RUN;
    if (bus.mem_busy)                   state_nxt = S_MEM_WAIT;
    else if (state == S_LU_STALL)       state_nxt = S_RUN;
    else if (redirect)                  state_nxt = S_REDIRECT;
    else if (stall)                     state_nxt = S_LU_STALL;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_RUN;
    else        state <= state_nxt;
  end

  assign bus.ctrl_state = state;

  hazard_wait_cnt #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wait_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .busy    (bus.mem_busy),
    .timeout (bus.mem_timeout)
  );

`ifdef HAZARD_PERF_EN
  // Free-running event counters, wrapping at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.perf_stall_cnt  <= '0;
      bus.perf_flush_cnt  <= '0;
      bus.perf_freeze_cnt <= '0;
    end else begin
      if (stall)        bus.perf_stall_cnt  <= bus.perf_stall_cnt + 32'd1;
      if (redirect)     bus.perf_flush_cnt  <= bus.perf_flush_cnt + 32'd1;
      if (bus.mem_busy) bus.perf_freeze_cnt <= bus.perf_freeze_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with MEM_TIMEOUT=4.
// Output vector order: {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en}.
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  localparam logic [6:0] O_RUN    = 7'b1101011;
  localparam logic [6:0] O_STALL  = 7'b0001111;
  localparam logic [6:0] O_BRANCH = 7'b1111111;
  localparam logic [6:0] O_FREEZE = 7'b0000000;

  logic clk = 1'b0;
  logic rst_n;
  int   passed = 0;
  int   total  = 0;

  hazard_ctrl_if #(.REG_AW(5)) bus ();

  hazard_ctrl #(.REG_AW(5), .MEM_TIMEOUT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [6:0] outs;
  assign outs = {bus.pc_en, bus.if_id_en, bus.if_id_flush, bus.id_ex_en,
                 bus.id_ex_flush, bus.ex_mem_en, bus.mem_wb_en};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic drive(input logic ld, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic u1, input logic [4:0] rs2, input logic u2,
                       input logic br, input logic busy);
    bus.ld_E       = ld;
    bus.rd_addr_E  = rd;
    bus.rs1_addr_D = rs1;
    bus.rs1_used_D = u1;
    bus.rs2_addr_D = rs2;
    bus.rs2_used_D = u2;
    bus.br_taken_E = br;
    bus.mem_busy   = busy;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0);
    chk("reset_outs", 32'(outs), 32'(O_RUN));
    chk("reset_state", 32'(bus.ctrl_state), 32'(S_RUN));
    chk("reset_timeout", 32'(bus.mem_timeout), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // ld x5 in EX, ID reads x5 via rs1: one bubble
    drive(1, 5'd5, 5'd5, 1, 5'd3, 1, 0, 0);
    chk("lu_rs1_outs", 32'(outs), 32'(O_STALL));
    tick();
    chk("lu_rs1_state", 32'(bus.ctrl_state), 32'(S_LU_STALL));
    drive(0, 5'd0, 5'd5, 1, 5'd3, 1, 0, 0);
    chk("lu_after_outs", 32'(outs), 32'(O_RUN));
    tick();
    chk("lu_after_state", 32'(bus.ctrl_state), 32'(S_RUN));

    // ld x0: never stalls
    drive(1, 5'd0, 5'd0, 1, 5'd0, 1, 0, 0);
    chk("ld_x0_outs", 32'(outs), 32'(O_RUN));
    tick();
    chk("ld_x0_state", 32'(bus.ctrl_state), 32'(S_RUN));

    // match on rs2 but rs2 not used: no stall; then used: stall
    drive(1, 5'd7, 5'd1, 1, 5'd7, 0, 0, 0);
    chk("rs2_unused_outs", 32'(outs), 32'(O_RUN));
    drive(1, 5'd7, 5'd1, 0, 5'd7, 1, 0, 0);
    chk("rs2_used_outs", 32'(outs), 32'(O_STALL));
    tick();
    drive(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0);
    tick();

    // taken branch wins over load-use
    drive(1, 5'd5, 5'd5, 1, 5'd0, 0, 1, 0);
    chk("br_lu_outs", 32'(outs), 32'(O_BRANCH));
    tick();
    chk("br_no_stall_state", 32'(bus.ctrl_state == S_LU_STALL), 32'd0);
    drive(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0);
    tick();

    // mem_busy 3 cycles with pending branch: freeze, then redirect on release
    drive(0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 1);
    chk("freeze_outs", 32'(outs), 32'(O_FREEZE));
    tick();
    chk("freeze_state", 32'(bus.ctrl_state), 32'(S_MEM_WAIT));
    chk("freeze_outs_c2", 32'(outs), 32'(O_FREEZE));
    tick();
    tick();
    chk("freeze_state_c3", 32'(bus.ctrl_state), 32'(S_MEM_WAIT));
    drive(0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0);
    chk("release_redirect_outs", 32'(outs), 32'(O_BRANCH));
    chk("busy3_no_timeout", 32'(bus.mem_timeout), 32'd0);
    tick();
    drive(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0);
    tick();
    chk("post_redirect_state", 32'(bus.ctrl_state), 32'(S_RUN));

    // mem_busy 4 cycles hits MEM_TIMEOUT=4
    drive(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1);
    tick();
    tick();
    tick();
    chk("timeout_after3", 32'(bus.mem_timeout), 32'd0);
    tick();
    chk("timeout_after4", 32'(bus.mem_timeout), 32'd1);
    drive(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0);
    tick();
    tick();
    chk("timeout_sticky", 32'(bus.mem_timeout), 32'd1);
    chk("timeout_release_outs", 32'(outs), 32'(O_RUN));

    // reset during S_MEM_WAIT
    drive(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1);
    tick();
    chk("pre_reset_state", 32'(bus.ctrl_state), 32'(S_MEM_WAIT));
    rst_n = 1'b0;
    #1;
    chk("mid_reset_state", 32'(bus.ctrl_state), 32'(S_RUN));
    chk("mid_reset_timeout", 32'(bus.mem_timeout), 32'd0);
`ifdef HAZARD_PERF_EN
    chk("mid_reset_perf_stall", bus.perf_stall_cnt, 32'd0);
    chk("mid_reset_perf_flush", bus.perf_flush_cnt, 32'd0);
    chk("mid_reset_perf_freeze", bus.perf_freeze_cnt, 32'd0);
`endif
    drive(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0);
    chk("mid_reset_outs", 32'(outs), 32'(O_RUN));
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_reset_state", 32'(bus.ctrl_state), 32'(S_RUN));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
